// File: rtl/music_pkg.sv
// Shared definitions for the KeyTunePlayer playback address sequencer:
// state encoding, field widths and the note RAM word layout.
package music_pkg;

  localparam int NOTE_W = 5;
  localparam int BEAT_W = 3;
  localparam int ADDR_W = 12;
  localparam int RAM_W  = 8;

  // RAM word: [7:3] note code, [2:0] beats-1
  localparam int NOTE_MSB = 7;
  localparam int NOTE_LSB = 3;
  localparam int BEAT_MSB = 2;
  localparam int BEAT_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_SEEK  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/beat_tick_gen.sv
// Beat timebase: counts enabled sys_clk cycles and emits a one-cycle tick
// every BEAT_CYCLES enabled cycles. Dropping en freezes the count in place.
module beat_tick_gen #(
  parameter int BEAT_CYCLES = 25_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEAT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Next count: clear, hold while disabled, wrap after the tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/music_addr_seq.sv
// Playback address sequencer: walks the note RAM, holds each note for its
// beat count, supports pause/stop/restart. Define MUSIC_SEEK_EN to build the
// seek path (seek_pos -> RAM address via a 13-bit repeated-add accumulator).
module music_addr_seq
  import music_pkg::*;
#(
  parameter int BEAT_CYCLES = 25_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic [4:0]        seek_pos,
  input  logic              seek,
  input  logic [ADDR_W-1:0] song_len,
  input  logic [RAM_W-1:0]  ram_data,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] music_len,
  output logic [NOTE_W-1:0] note_out,
  output logic              playing,
  output logic              paused,
  output logic              done
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic                paused_q, paused_d;
  logic                playing_q, playing_d;
  logic                seek_go;
  logic                tick;

`ifdef MUSIC_SEEK_EN
  logic [ADDR_W:0]     acc_q, acc_d;
  logic [4:0]          n_q, n_d;
`else
  logic                unused_seek;
  assign unused_seek = ^{seek, seek_pos};
`endif

  beat_tick_gen #(
    .BEAT_CYCLES (BEAT_CYCLES)
  ) u_tick (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (state_q == S_WAIT),
    .en        ((state_q == S_HOLD) && !paused_q),
    .tick      (tick)
  );

  assign ram_addr_out = addr_q;
  assign music_len    = len_q;
  assign ram_rd_en    = (state_q == S_FETCH);
  assign done         = (state_q == S_DONE);
  assign playing      = playing_q;
  assign paused       = paused_q;
  // Internal note survives a pause; only the port is silenced.
  assign note_out     = paused_q ? '0 : note_q;

  // Next-state decode; pulse priority is stop > seek > start > pause.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    note_d    = note_q;
    beats_d   = beats_q;
    paused_d  = paused_q;
    playing_d = playing_q;
    seek_go   = 1'b0;
`ifdef MUSIC_SEEK_EN
    acc_d     = acc_q;
    n_d       = n_q;
    seek_go   = seek && !((state_q == S_IDLE) && (len_q == '0));
`endif
    if (stop) begin
      state_d   = S_IDLE;
      addr_d    = '0;
      note_d    = '0;
      paused_d  = 1'b0;
      playing_d = 1'b0;
    end else if (seek_go) begin
`ifdef MUSIC_SEEK_EN
      state_d = S_SEEK;
      acc_d   = '0;
      n_d     = seek_pos;
`endif
    end else if (start) begin
      len_d    = song_len;
      addr_d   = '0;
      paused_d = 1'b0;
      if (song_len == '0) begin
        state_d   = S_DONE;
        note_d    = '0;
        playing_d = 1'b0;
      end else begin
        state_d   = S_FETCH;
        playing_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: ;
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          note_d  = ram_data[NOTE_MSB:NOTE_LSB];
          beats_d = ram_data[BEAT_MSB:BEAT_LSB];
          state_d = S_HOLD;
        end
        S_HOLD: begin
          // A pause pulse landing on the beat-boundary tick is dropped.
          if (tick) begin
            if (beats_q != '0) begin
              beats_d = beats_q - 1'b1;
            end else if (addr_q == len_q - 1'b1) begin
              state_d   = S_DONE;
              note_d    = '0;
              playing_d = 1'b0;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = S_FETCH;
            end
          end else if (pause) begin
            paused_d = ~paused_q;
          end
        end
        S_SEEK: begin
`ifdef MUSIC_SEEK_EN
          if (n_q == '0) begin
            addr_d    = (acc_q > ({1'b0, len_q} - 1'b1)) ? len_q - 1'b1 : acc_q[ADDR_W-1:0];
            paused_d  = 1'b0;
            playing_d = 1'b1;
            state_d   = S_FETCH;
          end else begin
            acc_d = acc_q + {5'd0, len_q[ADDR_W-1:4]};
            n_d   = n_q - 1'b1;
          end
`else
          state_d = S_IDLE;
`endif
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      note_q    <= '0;
      beats_q   <= '0;
      paused_q  <= 1'b0;
      playing_q <= 1'b0;
`ifdef MUSIC_SEEK_EN
      acc_q     <= '0;
      n_q       <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      note_q    <= note_d;
      beats_q   <= beats_d;
      paused_q  <= paused_d;
      playing_q <= playing_d;
`ifdef MUSIC_SEEK_EN
      acc_q     <= acc_d;
      n_q       <= n_d;
`endif
    end
  end

endmodule

// File: doc/music_addr_seq.md
# music_addr_seq

Playback address sequencer for KeyTunePlayer. It walks the note RAM from address 0 to `music_len-1` and holds each entry for its encoded number of beats. It drives `ram_addr_out` and `music_len` to the progress-bar logic and `note_out` to the tone generator. It also performs the inverse of the progress mapping: a 5-bit seek position becomes a RAM address.

## Interface
- `BEAT_CYCLES`, default 25_000_000: sys_clk cycles per beat (0.25 s at 100 MHz).
- `sys_clk`  in  1  100 MHz clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begin playback from address 0.
- `pause`  in  1  one-cycle pulse; toggle pause while playing.
- `stop`  in  1  one-cycle pulse; abort and return to idle.
- `seek_pos`  in  5  target progress, in units of `music_len>>4`.
- `seek`  in  1  one-cycle pulse; jump to `seek_pos` (SEEK_EN only).
- `song_len`  in  12  number of RAM entries, sampled on `start`.
- `ram_data`  in  8  RAM read data, valid 1 cycle after `ram_rd_en`.
- `ram_addr_out`  out  12  current RAM address.
- `ram_rd_en`  out  1  RAM read strobe.
- `music_len`  out  12  latched `song_len`.
- `note_out`  out  5  current note code; 0 means rest.
- `playing`  out  1  high from the first FETCH after `start` until DONE or IDLE, including while paused.
- `paused`  out  1  pause active.
- `done`  out  1  one-cycle pulse when the last entry finishes.

## Operation
- RAM word layout: bits [7:3] are the note code; bits [2:0] are beats-1, so a note lasts 1–8 beats.
- States: IDLE, FETCH, WAIT, HOLD, SEEK, DONE.
- IDLE
  - On `start`, latch `music_len<=song_len` and set `ram_addr_out<=0`.
  - If `song_len==0`, go to DONE; otherwise go to FETCH.
- FETCH: assert `ram_rd_en` for one cycle, then go to WAIT.
- WAIT: capture `note_out<=ram_data[7:3]` and `beats<=ram_data[2:0]`, clear the beat counter, then go to HOLD.
- HOLD
  - Count beat ticks.
  - When the tick occurs with `beats==0`:
    - If `ram_addr_out==music_len-1`, go to DONE.
    - Otherwise increment `ram_addr_out` and go to FETCH.
  - When the tick occurs with `beats!=0`, decrement `beats`.
- DONE
  - Pulse `done` for one cycle.
  - Clear `note_out` and `playing`.
  - Keep `ram_addr_out` at its final value, then go to IDLE.
- Pause
  - Toggled only in HOLD.
  - While paused, the beat counter freezes and `note_out` is forced to 0 on the port; the internal note is preserved.
  - Resume continues the remaining count exactly where it stopped.
- SEEK
  - Accepted in any state except IDLE when `music_len==0`.
  - Set `acc<=0` and `n<=seek_pos`.
  - Each cycle: `acc<=acc+(music_len>>4)` and `n<=n-1`, until `n==0`.
  - Then set `ram_addr_out<=min(acc, music_len-1)`, clear `paused`, set `playing`, and go to FETCH.
  - `acc` is 13 bits wide so the compare does not overflow.
- Priority when pulses coincide: `stop` > `seek` > `start` > `pause`.
  - `stop` in any state goes to IDLE, clears `note_out`, `paused` and `playing`, and sets `ram_addr_out<=0`.
- `start` while not in IDLE restarts from address 0.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - beat counter 0.
- `start` to `ram_rd_en`: 1 cycle, since FETCH follows the cycle after the pulse.
- `start` to `note_out` valid: 3 cycles.
- Entry hold time: `(beats+1)*BEAT_CYCLES` cycles. The tick fires when the counter reaches `BEAT_CYCLES-1`.
- Inter-note gap: 3 cycles (FETCH, WAIT, plus the transition cycle). `note_out` keeps the old value through the gap.
- `ram_addr_out` changes only on HOLD exit, SEEK completion, `start` or `stop`. It is stable for the whole note.
- Seek latency: `seek_pos+2` cycles to FETCH.
- `music_len<16` gives a step of 0, so a seek always resolves to address 0.
- Asynchronous reset mid-note aborts immediately. No `done` pulse is generated.

## Configuration
- `MUSIC_SEEK_EN`
  - Defined: the SEEK state, the `seek`/`seek_pos` logic and the 13-bit accumulator are built.
  - Undefined: `seek` and `seek_pos` are ignored, and SEEK is unreachable and not synthesized.
  - All other behaviour is identical.

## Structure
- Package `music_pkg` holds:
  - the state encoding;
  - `NOTE_W=5`, `BEAT_W=3`, `ADDR_W=12`;
  - RAM word field positions.
- Sub-module `beat_tick_gen`, parameter `BEAT_CYCLES`: ports `clr` and `en` (en low while paused), output a one-cycle `tick`.

## Test plan
- `BEAT_CYCLES=4`, `song_len=3`, RAM `{0x08,0x11,0x1A}` → notes 1,2,3 held 4,8,12 cycles; addresses 0,1,2; `done` pulses once; `playing` then falls.
- `song_len=0`, `start` → DONE on the next cycle; `done` pulses; `ram_rd_en` never asserts.
- `pause` mid-note after 2 ticks, hold 20 cycles, `pause` again → `note_out=0` while paused; the note resumes with exactly the remaining cycles.
- `MUSIC_SEEK_EN`, `music_len=160`, `seek_pos=5` during HOLD → address 50 after 7 cycles; `paused` cleared.
- `MUSIC_SEEK_EN`, `music_len=160`, `seek_pos=31` → clamped to address 159; the entry plays, then `done`.
- `stop` and `pause` in the same cycle during HOLD → IDLE; `ram_addr_out=0`; `paused=0`; `playing=0`.
